gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
Shares one WIDTH-bit bitwise logic unit among NREQ requesters. The logic unit is built from the team's structural gate cells (AND/OR/NAND/NOR/XOR/XNOR/NOT).
- Arbitration is round-robin.
- Each requester uses a valid/ready handshake.
- The result is registered and returned on a single valid/ready response channel, tagged with the requester ID.
- The block sits between lab test requesters (switch/button sequencers, self-check FSMs) and the shared gate datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
IDW, $clog2(NREQ), requester ID width (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
req_op  in  NREQ*3  per-requester opcode, requester i at bits [3i+2:3i]
req_a  in  NREQ*WIDTH  per-requester operand A, slice i
req_b  in  NREQ*WIDTH  per-requester operand B, slice i
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer ready
rsp_data  out  WIDTH  result
rsp_id  out  IDW  index of requester that owns rsp_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ptr=NREQ-1 (requester 0 has first priority).
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0, operand/op capture regs=0.
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A. All 8 are defined; there is no illegal op.
- Grant (combinational):
  - Search req_valid starting at (ptr+1) mod NREQ, wrapping.
  - The first set bit is the candidate; grant is one-hot.
- FSM states:
  - IDLE:
    - If any req_valid: req_ready[cand]=1 this cycle; capture op/a/b of cand and cand ID; ptr<=cand; next EXEC.
    - Otherwise stay in IDLE with req_ready=0.
  - EXEC:
    - Logic unit evaluates the captured operands.
    - rsp_data<=result, rsp_id<=captured ID, rsp_valid<=1; next RESP.
  - RESP:
    - Hold rsp_valid/rsp_data/rsp_id stable until rsp_ready=1.
    - On rsp_valid&&rsp_ready: rsp_valid<=0; next IDLE.
- Latency and throughput:
  - Accept at cycle T, rsp_valid high at T+2.
  - With rsp_ready held high, the earliest next accept is T+3, so peak throughput is one op per 3 cycles.
- Handshake rules:
  - Requester must hold req_valid and operands until it sees req_ready. Operands are sampled only in the req_ready cycle.
  - req_ready is never asserted outside IDLE. It is never asserted to a requester whose req_valid is 0.
  - A requester dropping req_valid before grant is legal; it is simply skipped.
- Boundary conditions:
  - All NREQ valid continuously: grants rotate strictly 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 grants.
  - Single requester repeatedly valid: it is granted every transaction (ptr wrap to itself).
  - rsp_ready low indefinitely: block stalls in RESP and accepts no new requests (busy=1).
  - rsp_ready high during EXEC: no effect; response still appears in RESP.
  - Reset asserted mid-EXEC/RESP: in-flight op is discarded, outputs immediately return to reset values, no response is emitted.
- Width rule: bitwise per bit, no carries; result width equals WIDTH exactly.

Decomposition:
- Package gate_unit_pkg holds:
  - opcode localparams OP_AND..OP_PASS (3-bit)
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
- Sub-module bitwise_logic_unit:
  - Purely combinational; inputs op, a, b; output y; all WIDTH bits.
  - Built by per-bit instantiation of the team's structural gate modules plus an 8:1 op mux.
- The arbiter FSM, round-robin pointer and capture registers stay in gate_unit_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-RESP with rsp_valid=1 -> rsp_valid, busy, req_ready drop to 0 asynchronously; after release, first grant goes to requester 0.
- Single op: req 2 valid, op=5 (XNOR), a=8'hA5, b=8'h0F, rsp_ready=1 -> req_ready=4'b0100 at T, rsp_valid at T+2 with rsp_data=8'h55, rsp_id=2.
- Fairness: all four req_valid held high, op=0 (AND), a=8'hFF, b=8'h3C, rsp_ready=1 -> grant order 0,1,2,3,0,1 at cycles T, T+3, T+6…; each rsp_data=8'h3C.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready stays 0 despite pending requests; rsp_ready=1 -> IDLE next cycle, next grant the following accept.
- Op sweep: ops 0..7 with a=8'hC3, b=8'h5A -> results 42, DB, BD, 24, 99, 66, 3C, C3 (hex).
- Skip/withdraw: ptr=1, req_valid=4'b0101, requester 2 deasserts before grant -> requester 0 granted (wrap), req_ready[2] never asserted.

Source files
------------

// File: rtl/gate_unit_pkg.sv
// gate_unit_pkg
// Shared definitions for the gate-unit arbiter slice:
//   - 3-bit opcodes understood by bitwise_logic_unit
//   - arbiter FSM state encoding
package gate_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_unit_arbiter_logic.sv
// Structural gate cells and the bitwise logic unit built from them.
//   and2_cell/or2_cell/nand2_cell/nor2_cell/xor2_cell/xnor2_cell : a, b -> y
//   not1_cell : a -> y
//   bitwise_logic_unit : op[2:0], a[WIDTH], b[WIDTH] -> y[WIDTH], combinational
module and2_cell (input logic a, input logic b, output logic y);
    assign y = a & b;
endmodule

module or2_cell (input logic a, input logic b, output logic y);
    assign y = a | b;
endmodule

module nand2_cell (input logic a, input logic b, output logic y);
    assign y = ~(a & b);
endmodule

module nor2_cell (input logic a, input logic b, output logic y);
    assign y = ~(a | b);
endmodule

module xor2_cell (input logic a, input logic b, output logic y);
    assign y = a ^ b;
endmodule

module xnor2_cell (input logic a, input logic b, output logic y);
    assign y = ~(a ^ b);
endmodule

module not1_cell (input logic a, output logic y);
    assign y = ~a;
endmodule

module bitwise_logic_unit
    import gate_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] and_y, or_y, nand_y, nor_y, xor_y, xnor_y, not_y;

    // Every gate is evaluated on every bit; the op mux selects one vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        and2_cell  u_and  (.a(a[gi]), .b(b[gi]), .y(and_y[gi]));
        or2_cell   u_or   (.a(a[gi]), .b(b[gi]), .y(or_y[gi]));
        nand2_cell u_nand (.a(a[gi]), .b(b[gi]), .y(nand_y[gi]));
        nor2_cell  u_nor  (.a(a[gi]), .b(b[gi]), .y(nor_y[gi]));
        xor2_cell  u_xor  (.a(a[gi]), .b(b[gi]), .y(xor_y[gi]));
        xnor2_cell u_xnor (.a(a[gi]), .b(b[gi]), .y(xnor_y[gi]));
        not1_cell  u_not  (.a(a[gi]), .y(not_y[gi]));
    end

    always_comb begin
        y = a;
        case (op)
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_NAND: y = nand_y;
            OP_NOR:  y = nor_y;
            OP_XOR:  y = xor_y;
            OP_XNOR: y = xnor_y;
            OP_NOT:  y = not_y;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
// Round-robin shares one bitwise logic unit among NREQ requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_op/a/b        : per-requester packed opcode and operands
//   rsp_valid/ready   : single response channel, rsp_data tagged with rsp_id
//   busy              : high whenever the FSM is not in IDLE
module gate_unit_arbiter
    import gate_unit_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IDW-1:0]   id_reg, id_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic [IDW-1:0]   rsp_id_reg, rsp_id_next;

    logic [2:0]       op_arr [NREQ];
    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];

    logic [NREQ-1:0]  grant;
    logic             cand_found;
    logic [IDW-1:0]   cand_id;
    int               idx;
    logic [WIDTH-1:0] logic_y;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[3*gi +: 3];
        assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
        assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    end

    // Round-robin search from ptr+1. Scanning from the farthest slot toward
    // the nearest lets the nearest valid requester overwrite the others.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        idx        = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[idx[IDW-1:0]]) begin
                cand_found = 1'b1;
                cand_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        op_next        = op_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        id_next        = id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_id_next    = rsp_id_reg;
        grant          = '0;
        case (state_reg)
            IDLE: begin
                if (cand_found) begin
                    grant[cand_id] = 1'b1;
                    op_next        = op_arr[cand_id];
                    a_next         = a_arr[cand_id];
                    b_next         = b_arr[cand_id];
                    id_next        = cand_id;
                    ptr_next       = cand_id;
                    state_next     = EXEC;
                end
            end
            EXEC: begin
                rsp_data_next  = logic_y;
                rsp_id_next    = id_reg;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= IDW'(NREQ - 1);
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            op_reg        <= op_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            id_reg        <= id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_id_reg    <= rsp_id_next;
        end
    end

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_logic (
        .op (op_reg),
        .a  (a_reg),
        .b  (b_reg),
        .y  (logic_y)
    );

    // The state register already reads IDLE during reset, so the grant
    // strobe is masked explicitly to keep req_ready low while rst_n is low.
    assign req_ready = rst_n ? grant : '0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side view and the reference arbitration state
    logic [NREQ-1:0]  v;
    logic [2:0]       op_t [NREQ];
    logic [WIDTH-1:0] a_t  [NREQ];
    logic [WIDTH-1:0] b_t  [NREQ];
    int               last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_op[3*i +: 3]         = op_t[i];
            req_a[WIDTH*i +: WIDTH]  = a_t[i];
            req_b[WIDTH*i +: WIDTH]  = b_t[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Next owner: first valid requester after the previous owner, wrapping.
    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One arbitration round starting in IDLE. v_exec / v_resp are the
    // requester valids presented during the EXEC and RESP cycles.
    task automatic txn(input int stall, input logic [NREQ-1:0] v_exec,
                       input logic [NREQ-1:0] v_resp, input bit scramble);
        int g;
        logic [WIDTH-1:0] ey;
        logic [2:0] eop;
        drive();
        #3;
        g = model_grant();
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        if (g < 0) begin
            check("none_ready", 32'(req_ready), 32'd0);
            check("none_busy", 32'(busy), 32'd0);
            tick();
            check("none_busy_after", 32'(busy), 32'd0);
            $display("txn: no requester valid, stays idle");
            return;
        end
        check("grant", 32'(req_ready), 32'(1) << g);
        check("idle_busy", 32'(busy), 32'd0);
        eop = op_t[g];
        ey  = ref_op(op_t[g], a_t[g], b_t[g]);
        tick();
        v = v_exec;
        if (scramble) begin
            op_t[g] = 3'($urandom);
            a_t[g]  = WIDTH'($urandom);
            b_t[g]  = WIDTH'($urandom);
        end
        drive();
        #3;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        v = v_resp;
        rsp_ready = (stall == 0);
        drive();
        #3;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_data", 32'(rsp_data), 32'(ey));
        check("resp_id", 32'(rsp_id), 32'(g));
        check("resp_ready_low", 32'(req_ready), 32'd0);
        for (int k = 1; k <= stall; k++) begin
            tick();
            if (k == stall) rsp_ready = 1'b1;
            #3;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'(ey));
            check("stall_id", 32'(rsp_id), 32'(g));
            check("stall_ready_low", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        tick();
        last = g;
        $display("txn: grant %0d op %0d result %h stall %0d", g, eop, ey, stall);
    endtask

    initial begin
        rsp_ready = 1'b1;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_t[i] = '0;
            a_t[i]  = '0;
            b_t[i]  = '0;
        end
        drive();
        rst_n = 1'b0;
        last  = NREQ - 1;

        // Reset state, with every requester valid
        repeat (2) @(posedge clk);
        #1;
        v = '1;
        drive();
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        v = '0;
        drive();
        tick();
        rst_n = 1'b1;
        tick();

        // Single op: requester 2 XNOR
        v = 4'b0100;
        op_t[2] = 3'd5; a_t[2] = 8'hA5; b_t[2] = 8'h0F;
        txn(0, 4'b0000, 4'b0000, 1'b0);

        // Fairness: all valid, held continuously
        v = '1;
        for (int i = 0; i < NREQ; i++) begin
            op_t[i] = 3'd0; a_t[i] = 8'hFF; b_t[i] = 8'h3C;
        end
        for (int k = 0; k < 6; k++) txn(0, '1, '1, 1'b0);

        // Back-pressure for 10 cycles, then the next grant
        txn(10, '1, '1, 1'b0);
        txn(0, '1, '1, 1'b0);

        // Op sweep on requester 1 alone
        v = 4'b0010;
        for (int o = 0; o < 8; o++) begin
            op_t[1] = 3'(o); a_t[1] = 8'hC3; b_t[1] = 8'h5A;
            txn(0, 4'b0010, 4'b0010, 1'b0);
        end

        // Skip/withdraw: ptr=1, requester 2 withdraws before IDLE
        op_t[0] = 3'd4; a_t[0] = 8'h12; b_t[0] = 8'h34;
        op_t[2] = 3'd1; a_t[2] = 8'h55; b_t[2] = 8'hAA;
        v = 4'b0010;
        txn(0, 4'b0101, 4'b0001, 1'b0);
        txn(0, 4'b0000, 4'b0000, 1'b0);

        // Nothing valid
        v = '0;
        txn(0, '0, '0, 1'b0);

        // Randomized traffic with operand scrambling after grant
        for (int n = 0; n < 30; n++) begin
            v = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                op_t[i] = 3'($urandom);
                a_t[i]  = WIDTH'($urandom);
                b_t[i]  = WIDTH'($urandom);
            end
            txn($urandom_range(0, 3), v, v, 1'b1);
        end

        // Reset asserted mid-RESP
        v = 4'b0001;
        op_t[0] = 3'd4; a_t[0] = 8'hF0; b_t[0] = 8'h0F;
        rsp_ready = 1'b0;
        drive();
        tick();
        tick();
        #3;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        v = '1;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        last = NREQ - 1;
        txn(0, '1, '1, 1'b0);
        txn(0, '1, '1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
